gcd_req_issue: RTL and testbench

//  Upstream operand stage for the GCD unit. Accepts (A,B) operand pairs over a valid/ready port.

---
 rtl/gcd_req_issue.sv | 189 ++++++++++++++++++
 tb/tb_gcd_req_issue.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_req_issue.sv
// gcd_req_issue
//   Upstream operand stage for the GCD core. Operand pairs (A,B) arrive over a
//   valid/ready port, are buffered in a DEPTH-entry FIFO and are issued to the
//   core one at a time. Only one operation is ever in flight: the next pair is
//   popped only after the core has returned a result and the FSM is back in idle.
//
// Parameters
//   W      operand width in bits (>= 2)
//   DEPTH  FIFO entries, power of two (>= 2)
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         asynchronous reset, active-high (shared with the core)
//   in_valid_i    upstream pair valid
//   in_ready_o    FIFO not full (registered)
//   in_a_i/in_b_i operand pair from upstream
//   gcd_req_o     one-cycle start pulse to the core (registered)
//   gcd_a_o/b_o   operands to the core, held until the next issue
//   gcd_busy_i    core busy (CALC/DONE)
//   gcd_valid_i   core result valid, one-cycle pulse
//   fifo_count_o  number of buffered pairs
//   idle_o        FIFO empty and FSM idle
//   issued_cnt_o  (only with GCD_ISSUE_CNT_EN) count of issued requests, wraps
//
// Configuration
//   GCD_ISSUE_CNT_EN  when defined, adds the 32-bit issued_cnt_o request counter.

module gcd_req_issue #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [W-1:0]             in_a_i,
    input  logic [W-1:0]             in_b_i,
    output logic                     gcd_req_o,
    output logic [W-1:0]             gcd_a_o,
    output logic [W-1:0]             gcd_b_o,
    input  logic                     gcd_busy_i,
    input  logic                     gcd_valid_i,
    output logic [$clog2(DEPTH):0]   fifo_count_o,
`ifdef GCD_ISSUE_CNT_EN
    output logic                     idle_o,
    output logic [31:0]              issued_cnt_o
`else
    output logic                     idle_o
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StStart,
        StRun
    } state_e;

    state_e          state_q;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0]     wr_ptr_q, wr_ptr_d;
    logic [PW:0]     rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count;
    logic            full_d;
    logic            in_ready_q;

    logic [W-1:0]    mem_a_q [DEPTH];
    logic [W-1:0]    mem_b_q [DEPTH];

    logic            req_q;
    logic [W-1:0]    a_q, b_q;

    logic            push;
    logic            pop;

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    assign count = wr_ptr_q - rd_ptr_q;

    // in_ready is a register, so a pop in the same cycle cannot admit a push.
    assign push = in_valid_i && in_ready_q;

    // Issue only from idle with a buffered pair and a quiet core. A pair pushed
    // this cycle is not yet counted, so there is no bypass path.
    assign pop = (state_q == StIdle) && (count != '0) && !gcd_busy_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop};
        full_d   = (wr_ptr_d[PW] != rd_ptr_d[PW]) &&
                   (wr_ptr_d[PW-1:0] == rd_ptr_d[PW-1:0]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            in_ready_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            in_ready_q <= !full_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_a_q[wr_ptr_q[PW-1:0]] <= in_a_i;
            mem_b_q[wr_ptr_q[PW-1:0]] <= in_b_i;
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM with registered request and operands
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Result pulses seen here are protocol errors and ignored.
                    if (pop) begin
                        a_q     <= mem_a_q[rd_ptr_q[PW-1:0]];
                        b_q     <= mem_b_q[rd_ptr_q[PW-1:0]];
                        req_q   <= 1'b1;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    req_q   <= 1'b0;
                    state_q <= StStart;
                end
                StStart: begin
                    // A result without a busy phase is a degenerate op that
                    // already finished; it wins over a simultaneous busy.
                    if (gcd_valid_i) begin
                        state_q <= StIdle;
                    end else if (gcd_busy_i) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (gcd_valid_i) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef GCD_ISSUE_CNT_EN
    logic [31:0] issued_cnt_q;

    // One increment per request cycle; natural 32-bit wrap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            issued_cnt_q <= '0;
        end else if (state_q == StReq) begin
            issued_cnt_q <= issued_cnt_q + 32'd1;
        end
    end

    assign issued_cnt_o = issued_cnt_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready_o   = in_ready_q;
    assign gcd_req_o    = req_q;
    assign gcd_a_o      = a_q;
    assign gcd_b_o      = b_q;
    assign fifo_count_o = count;
    assign idle_o       = (state_q == StIdle) && (count == '0);

endmodule

// File: tb/tb_gcd_req_issue.sv
// Directed testbench for gcd_req_issue (W=8, DEPTH=4). Drives inputs on the
// falling edge and samples outputs on the falling edge after each rising edge.

module tb_gcd_req_issue;

    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         gcd_req;
    logic [W-1:0] gcd_a;
    logic [W-1:0] gcd_b;
    logic         gcd_busy;
    logic         gcd_valid;
    logic [2:0]   fifo_count;
    logic         idle;
`ifdef GCD_ISSUE_CNT_EN
    logic [31:0]  issued_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int req_total = 0;
    int snap;

    gcd_req_issue #(
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_a_i       (in_a),
        .in_b_i       (in_b),
        .gcd_req_o    (gcd_req),
        .gcd_a_o      (gcd_a),
        .gcd_b_o      (gcd_b),
        .gcd_busy_i   (gcd_busy),
        .gcd_valid_i  (gcd_valid),
        .fifo_count_o (fifo_count),
`ifdef GCD_ISSUE_CNT_EN
        .idle_o       (idle),
        .issued_cnt_o (issued_cnt)
`else
        .idle_o       (idle)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each request cycle is seen at exactly one falling edge.
    always @(negedge clk) begin
        if (gcd_req === 1'b1) req_total++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push1(input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic issue_check(input logic [W-1:0] a, input logic [W-1:0] b);
        check("req_high", {31'd0, gcd_req}, 32'd1);
        check("op_a", {24'd0, gcd_a}, {24'd0, a});
        check("op_b", {24'd0, gcd_b}, {24'd0, b});
    endtask

    // Called in the START cycle: core goes busy, stays busy n cycles, then
    // pulses valid. Leaves the DUT in IDLE with the core quiet.
    task automatic finish_op(input int n);
        check("req_dropped", {31'd0, gcd_req}, 32'd0);
        gcd_busy = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            check("run_no_req", {31'd0, gcd_req}, 32'd0);
            check("run_not_idle", {31'd0, idle}, 32'd0);
            tick();
        end
        gcd_valid = 1'b1;
        tick();
        gcd_valid = 1'b0;
        gcd_busy  = 1'b0;
    endtask

    logic [W-1:0] ba [4];
    logic [W-1:0] bb [4];
    logic [W-1:0] fa [6];
    logic [W-1:0] fb [6];

    initial begin
        ba[0] = 8'd9;   bb[0] = 8'd6;
        ba[1] = 8'd7;   bb[1] = 8'd3;
        ba[2] = 8'd0;   bb[2] = 8'd5;
        ba[3] = 8'd255; bb[3] = 8'd17;
        for (int i = 0; i < 6; i++) begin
            fa[i] = W'(2 * i + 1);
            fb[i] = W'(2 * i + 2);
        end

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        gcd_busy  = 1'b0;
        gcd_valid = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req", {31'd0, gcd_req}, 32'd0);
        check("rst_count", {29'd0, fifo_count}, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd1);
        check("rst_a", {24'd0, gcd_a}, 32'd0);
        check("rst_b", {24'd0, gcd_b}, 32'd0);
        rst = 1'b0;
        tick();
        check("rel_ready", {31'd0, in_ready}, 32'd1);
        check("rel_idle", {31'd0, idle}, 32'd1);

        // Result pulse while idle is ignored
        gcd_valid = 1'b1;
        tick();
        gcd_valid = 1'b0;
        check("stray_valid_idle", {31'd0, idle}, 32'd1);
        check("stray_valid_req", {31'd0, gcd_req}, 32'd0);

        // Back-to-back: queue four pairs while the core holds busy
        gcd_busy = 1'b1;
        for (int i = 0; i < 4; i++) push1(ba[i], bb[i]);
        check("b2b_count", {29'd0, fifo_count}, 32'd4);
        check("b2b_ready", {31'd0, in_ready}, 32'd0);
        check("b2b_busy_blocks", {31'd0, gcd_req}, 32'd0);
        snap = req_total;
        gcd_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            issue_check(ba[i], bb[i]);
            check("b2b_count_dec", {29'd0, fifo_count}, 32'(3 - i));
            tick();
            finish_op(i + 1);
        end
        check("b2b_idle", {31'd0, idle}, 32'd1);
        check("b2b_req_pulses", 32'(req_total - snap), 32'd4);
`ifdef GCD_ISSUE_CNT_EN
        check("cnt_after_b2b", issued_cnt, 32'd4);
`endif

        // Single op: request appears two cycles after the push
        push1(8'd12, 8'd8);
        check("single_no_bypass", {31'd0, gcd_req}, 32'd0);
        check("single_count", {29'd0, fifo_count}, 32'd1);
        check("single_not_idle", {31'd0, idle}, 32'd0);
        tick();
        issue_check(8'd12, 8'd8);
        check("single_popped", {29'd0, fifo_count}, 32'd0);
        tick();
        finish_op(3);
        check("single_idle", {31'd0, idle}, 32'd1);

        // Fill, then full + simultaneous pop
        push1(fa[0], fb[0]);
        tick();
        issue_check(fa[0], fb[0]);
        gcd_busy = 1'b1;
        for (int i = 1; i < 5; i++) push1(fa[i], fb[i]);
        check("fill_count", {29'd0, fifo_count}, 32'd4);
        check("fill_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_a     = fa[5];
        in_b     = fb[5];
        tick();
        tick();
        check("full_held_count", {29'd0, fifo_count}, 32'd4);
        check("full_held_ready", {31'd0, in_ready}, 32'd0);
        gcd_valid = 1'b1;
        tick();
        gcd_valid = 1'b0;
        gcd_busy  = 1'b0;
        check("full_idle_count", {29'd0, fifo_count}, 32'd4);
        tick();
        check("full_pop_count", {29'd0, fifo_count}, 32'd3);
        check("full_pop_ready", {31'd0, in_ready}, 32'd1);
        issue_check(fa[1], fb[1]);
        tick();
        in_valid = 1'b0;
        check("late_push_count", {29'd0, fifo_count}, 32'd4);
        check("late_push_ready", {31'd0, in_ready}, 32'd0);
        finish_op(2);
        for (int i = 2; i < 6; i++) begin
            tick();
            issue_check(fa[i], fb[i]);
            tick();
            finish_op(1);
        end
        check("drain_idle", {31'd0, idle}, 32'd1);
        check("drain_count", {29'd0, fifo_count}, 32'd0);

        // Reset in the middle of a running op with pairs queued
        push1(8'd20, 8'd30);
        push1(8'd40, 8'd50);
        tick();
        gcd_busy = 1'b1;
        tick();
        push1(8'd60, 8'd70);
        check("pre_rst_count", {29'd0, fifo_count}, 32'd2);
        check("pre_rst_busy", {31'd0, idle}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_req", {31'd0, gcd_req}, 32'd0);
        check("mid_rst_count", {29'd0, fifo_count}, 32'd0);
        check("mid_rst_idle", {31'd0, idle}, 32'd1);
        check("mid_rst_a", {24'd0, gcd_a}, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        gcd_busy = 1'b0;
        tick();
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);
        check("post_rst_idle", {31'd0, idle}, 32'd1);
        snap = req_total;
        tick();
        tick();
        check("post_rst_no_issue", 32'(req_total - snap), 32'd0);

`ifdef GCD_ISSUE_CNT_EN
        // Counter wrap
        check("cnt_rst", issued_cnt, 32'd0);
        dut.issued_cnt_q = 32'hFFFF_FFFF;
        push1(8'd1, 8'd1);
        tick();
        tick();
        check("cnt_wrap", issued_cnt, 32'd0);
        finish_op(1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
